mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Request-side controller that sits directly upstream of the single-port register-file memory and is the only master of its port.
- Accepts burst read/write commands on a valid/ready request channel, streams write beats in, and drives the memory's write-enable, address and data signals.
- Captures the memory's registered read data into a 2-entry response buffer.
- Returns read beats on a valid/ready response channel and marks the last beat of each burst.

Parameters:
- WIDTH, 32, data word width; must match the memory.
- DEPTH, 16, memory depth in words; AW = $clog2(DEPTH).
- MAX_LEN, 8, maximum burst length in beats; LW = $clog2(MAX_LEN).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  command valid
- o_req_ready  out  1  command accepted when valid&ready
- i_req_we  in  1  1 = write burst, 0 = read burst
- i_req_addr  in  AW  start address
- i_req_len  in  LW  burst beats minus 1
- i_wdata_valid  in  1  write beat valid
- o_wdata_ready  out  1  write beat accepted
- i_wdata  in  WIDTH  write beat data
- o_rdata_valid  out  1  read beat valid
- i_rdata_ready  in  1  read beat consumed
- o_rdata  out  WIDTH  read beat data
- o_rdata_last  out  1  final beat of the read burst
- o_busy  out  1  state != IDLE
- o_mem_we  out  1  to memory i_we
- o_mem_addr  out  AW  to memory i_addr
- o_mem_data  out  WIDTH  to memory i_data
- i_mem_data  in  WIDTH  from memory o_data; valid 1 cycle after a we=0 address
- i_mem_valid  in  1  from memory o_valid; informational only, not used for capture

Behaviour:
- Reset (async): state=IDLE, counters=0, response buffer empty. Outputs: o_req_ready=0 during reset (1 after, in IDLE), all other outputs 0.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - o_req_ready=1.
  - On accept, latch addr→cur_addr, len→beats_left, and clear issued/captured counters.
  - Go to WRITE if we=1, else READ.
- WRITE:
  - o_wdata_ready=1.
  - o_mem_we = i_wdata_valid (combinational); o_mem_addr=cur_addr; o_mem_data=i_wdata.
  - Zero added latency: a beat is written at the same edge it is accepted.
  - Per accepted beat: cur_addr increments modulo DEPTH (DEPTH-1→0); beats_left decrements.
  - Accepting the beat with beats_left==0 → IDLE.
- READ:
  - o_mem_we=0. Issue a read at cur_addr when credit is available: (buffer occupancy + pending) < 2, or when the buffer pops in the same cycle.
  - pending is set the cycle after an issue. While pending, push i_mem_data into the buffer, tagged last = (captured beat index == latched len).
  - cur_addr wraps modulo DEPTH.
  - Sustained throughput is 1 beat/cycle when i_rdata_ready=1. First-beat latency: o_rdata_valid 2 cycles after request accept.
  - When all len+1 beats are issued and pending=0 → IDLE. The buffer keeps draining independently.
  - A new read may be accepted while the buffer still holds beats; credit rules prevent overflow.
- Response buffer: 2-entry FIFO of {last, data}.
  - o_rdata_valid = !empty; pop on valid&ready.
  - Push and pop in the same cycle are allowed, including when full.
- o_mem_addr in IDLE holds the last cur_addr; o_mem_we=0.
- Channel rules:
  - o_req_ready is 0 in WRITE/READ; i_req_* are ignored there.
  - o_wdata_ready is 0 outside WRITE; write beats are ignored there.
- Back-pressure: i_rdata_ready=0 stalls issue after at most 2 outstanding beats. No data is ever dropped or duplicated.
- Reset mid-burst: abort immediately, flush the buffer, perform no further memory writes. Beats already written stay written until the memory's own reset clears it.
- len=0: a single-beat burst; o_rdata_last is asserted on that beat.

Decomposition:
- Package mem_burst_pkg:
  - state_e enum {IDLE, WRITE, READ}
  - resp_t struct {logic last; logic [WIDTH-1:0] data}
  - localparams AW and LW
- Sub-module mem_resp_fifo: 2-entry FIFO, parameterized width, push/pop/full/empty, asynchronous reset to empty.

Test Plan:
- Write len=0, addr=3, data 0xDEADBEEF; then read len=0, addr=3 → o_mem_we high for exactly 1 cycle; o_rdata=0xDEADBEEF with o_rdata_last=1, 2 cycles after read accept.
- Write len=3 at addr=14 with data 0xA0..0xA3 → writes land at 14,15,0,1. Read len=3 at 14 → beats A0,A1,A2,A3 on consecutive cycles; last on A3.
- Read len=7 with i_rdata_ready=0 for 10 cycles → exactly 2 reads issued, o_rdata_valid held with first beat stable. Release ready → remaining 6 beats in order, no loss.
- Write len=3 with i_wdata_valid toggling 1,0,1,0,… → 4 writes to consecutive addresses; FSM returns to IDLE only after the 4th beat; i_req_valid during the burst is ignored.
- Assert i_rst_n=0 after 2 of 4 write beats → o_mem_we=0 from reset onward, FSM IDLE, o_req_ready=1 after release.
- Back-to-back read bursts (len=1, then len=1) with ready=1 → second request accepted the cycle FSM returns to IDLE; 4 beats with last on beats 2 and 4.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared types and default sizing for the burst controller slice.
package mem_burst_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int DEPTH_DEF   = 16;
  localparam int MAX_LEN_DEF = 8;

  localparam int AW = $clog2(DEPTH_DEF);
  localparam int LW = $clog2(MAX_LEN_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // One read beat as held in the response buffer.
  typedef struct packed {
    logic                 last;
    logic [WIDTH_DEF-1:0] data;
  } resp_t;

endpackage

// File: rtl/mem_burst_ctrl_fifo.sv
// Two-entry response FIFO. Push and pop may coincide, even when full.
module mem_resp_fifo #(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign o_full  = (cnt_q == 2'd2);
  assign o_empty = (cnt_q == 2'd0);
  assign o_data  = mem_q[rd_ptr_q];

  // Next-state: a pop frees the head slot, so a push into a full FIFO is legal alongside it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = i_pop && !o_empty;
    do_push  = i_push && (!o_full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // State registers; reset empties the FIFO and zeroes the storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller, sole master of a single-port register-file memory.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int MAX_LEN = MAX_LEN_DEF,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int LEN_W   = $clog2(MAX_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LEN_W-1:0]  i_req_len,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic              o_rdata_valid,
  input  logic              i_rdata_ready,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_rdata_last,
  output logic              o_busy,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WIDTH-1:0]  o_mem_data,
  input  logic [WIDTH-1:0]  i_mem_data,
  input  logic              i_mem_valid
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beats_left_q, beats_left_d;
  logic [LEN_W:0]     issued_q, issued_d;
  logic [LEN_W-1:0]   captured_q, captured_d;
  logic               pending_q, pending_d;
  logic               init_q;

  logic [ADDR_W-1:0]  addr_inc;
  logic               wbeat, issue, pop, credit, all_issued;
  logic [1:0]         occ;
  logic               fifo_full, fifo_empty;
  logic [WIDTH:0]     fifo_in, fifo_out;

  // Memory valid is redundant: capture timing is known from the issue cycle.
  logic unused_mem_valid;
  assign unused_mem_valid = i_mem_valid;

  assign addr_inc   = (cur_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;
  assign wbeat      = (state_q == WRITE) && i_wdata_valid;
  assign pop        = !fifo_empty && i_rdata_ready;
  assign occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign credit     = ((occ + {1'b0, pending_q}) < 2'd2) || pop;
  assign all_issued = (issued_q == ({1'b0, len_q} + 1'b1));
  assign fifo_in    = {(captured_q == len_q), i_mem_data};

  assign o_req_ready   = init_q && (state_q == IDLE);
  assign o_wdata_ready = (state_q == WRITE);
  assign o_busy        = (state_q != IDLE);
  assign o_mem_we      = wbeat;
  assign o_mem_addr    = cur_addr_q;
  assign o_mem_data    = (state_q == WRITE) ? i_wdata : '0;
  assign o_rdata_valid = !fifo_empty;
  assign o_rdata_last  = fifo_out[WIDTH];
  assign o_rdata       = fifo_out[WIDTH-1:0];

  // Next-state for the FSM, address walk and burst counters.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    len_d        = len_q;
    beats_left_d = beats_left_q;
    issued_d     = issued_q;
    captured_d   = captured_q;
    issue        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid && init_q) begin
          cur_addr_d   = i_req_addr;
          len_d        = i_req_len;
          beats_left_d = i_req_len;
          issued_d     = '0;
          captured_d   = '0;
          state_d      = i_req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wbeat) begin
          cur_addr_d   = addr_inc;
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        // Credit keeps buffered + in-flight beats at or below two.
        if (!all_issued && credit) begin
          issue      = 1'b1;
          cur_addr_d = addr_inc;
          issued_d   = issued_q + 1'b1;
        end
        if (all_issued && !pending_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pending_d = issue;
    if (pending_q) captured_d = captured_q + 1'b1;
  end

  // Control registers; reset aborts any burst in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      len_q        <= '0;
      beats_left_q <= '0;
      issued_q     <= '0;
      captured_q   <= '0;
      pending_q    <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      len_q        <= len_d;
      beats_left_q <= beats_left_d;
      issued_q     <= issued_d;
      captured_q   <= captured_d;
      pending_q    <= pending_d;
      init_q       <= 1'b1;
    end
  end

  // Memory read data is captured the cycle after its address was issued.
  mem_resp_fifo #(.W(WIDTH + 1)) u_resp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (pending_q),
    .i_data  (fifo_in),
    .i_pop   (pop),
    .o_data  (fifo_out),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: memory stub, reference memory, expected write/read queues.
module tb_mem_burst_ctrl;
  import mem_burst_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int D = DEPTH_DEF;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_req_valid = 1'b0, i_req_we = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [LW-1:0] i_req_len = '0;
  logic          i_wdata_valid = 1'b0;
  logic [W-1:0]  i_wdata = '0;
  logic          i_rdata_ready = 1'b0;
  logic [W-1:0]  i_mem_data;
  logic          i_mem_valid;
  logic          o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata_last, o_busy, o_mem_we;
  logic [W-1:0]  o_rdata, o_mem_data;
  logic [AW-1:0] o_mem_addr;

  always #5 i_clk = ~i_clk;

  mem_burst_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
    .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
    .o_rdata_last(o_rdata_last), .o_busy(o_busy),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data), .i_mem_valid(i_mem_valid)
  );

  // Single-port memory stub with registered read data; survives controller reset.
  logic [W-1:0] stub_mem [D];
  always @(posedge i_clk) begin
    if (o_mem_we) stub_mem[o_mem_addr] <= o_mem_data;
    i_mem_data  <= stub_mem[o_mem_addr];
    i_mem_valid <= !o_mem_we;
  end

  typedef struct { int addr; logic [W-1:0] data; } wexp_t;

  logic [W-1:0] ref_mem [D];
  wexp_t        exp_wr [$];
  resp_t        exp_rd [$];
  logic [W-1:0] wq [$];
  int           wlog [$];
  resp_t        rlog [$];
  int           rcyc [$];
  int checks = 0, errors = 0;
  int cyc = 0, we_cnt = 0, idle_cnt = 0, rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read-ready driver: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      0:       i_rdata_ready = 1'b1;
      1:       i_rdata_ready = ($urandom_range(0, 1) == 1);
      default: i_rdata_ready = 1'b0;
    endcase
  end

  // Compare process: every write and every delivered read beat against the model.
  always @(negedge i_clk) begin
    wexp_t we_e;
    resp_t rd_e;
    cyc++;
    if (i_rst_n) begin
      if (o_mem_we) begin
        we_cnt++;
        wlog.push_back(int'(o_mem_addr));
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          we_e = exp_wr.pop_front();
          chk("wr_addr", o_mem_addr, we_e.addr);
          chk("wr_data", o_mem_data, we_e.data);
          ref_mem[we_e.addr] = we_e.data;
        end
      end
      if (o_rdata_valid && i_rdata_ready) begin
        rlog.push_back('{last: o_rdata_last, data: o_rdata});
        rcyc.push_back(cyc);
        if (exp_rd.size() == 0) chk("unexpected_rbeat", 1, 0);
        else begin
          rd_e = exp_rd.pop_front();
          chk("rd_data", o_rdata, rd_e.data);
          chk("rd_last", o_rdata_last, rd_e.last);
        end
      end
      if (o_busy) chk("req_ready_while_busy", o_req_ready, 0);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_req(input logic we, input int addr, input int len);
    logic got;
    int   ok = 0;
    i_req_valid = 1'b1; i_req_we = we;
    i_req_addr = addr[AW-1:0]; i_req_len = len[LW-1:0];
    for (int n = 0; n < 300; n++) begin
      @(negedge i_clk);
      got = o_req_ready;
      if (!o_busy) idle_cnt++;
      tick();
      if (got) begin ok = 1; break; end
    end
    i_req_valid = 1'b0;
    if (ok == 0) chk("req_accept_timeout", 0, 1);
    else if (!we)
      for (int i = 0; i <= len; i++)
        exp_rd.push_back('{last: (i == len), data: ref_mem[(addr + i) % D]});
  endtask

  // vmode 0: random write-valid gaps; 1: strict toggle with request noise.
  task automatic write_burst(input int addr, input int len, input int vmode, input int nbeats);
    logic [W-1:0] bd [$];
    logic tog = 1'b1, acc;
    int   i = 0, guard = 0;
    for (int k = 0; k <= len; k++) begin
      bd.push_back(wq.size() > 0 ? wq.pop_front() : W'($urandom));
      exp_wr.push_back('{addr: (addr + k) % D, data: bd[k]});
    end
    send_req(1'b1, addr, len);
    if (vmode == 1) begin
      i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 4'd9; i_req_len = '0;
    end
    while (i < nbeats && guard < 400) begin
      i_wdata = bd[i];
      i_wdata_valid = (vmode == 1) ? tog : ($urandom_range(0, 3) != 0);
      tog = ~tog;
      @(negedge i_clk);
      chk("busy_during_write", o_busy, 1);
      acc = i_wdata_valid && o_wdata_ready;
      tick();
      if (acc) i++;
      guard++;
    end
    i_wdata_valid = 1'b0;
    i_req_valid   = 1'b0;
    if (i < nbeats) chk("wbeat_timeout", i, nbeats);
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge i_clk);
    while (o_busy && g < 300) begin tick(); @(negedge i_clk); g++; end
    if (o_busy) chk("idle_timeout", 1, 0);
    tick();
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_rd.size() > 0 && g < 400) begin tick(); g++; end
    if (exp_rd.size() > 0) chk("drain_timeout", exp_rd.size(), 0);
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, lat, ok;
    int waddr [4] = '{14, 15, 0, 1};

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rdata_valid", o_rdata_valid, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_wdata_ready", o_wdata_ready, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_rdata", o_rdata, 0);
    tick();
    i_rst_n = 1'b1;
    tick(); tick();
    @(negedge i_clk);
    chk("post_rst_req_ready", o_req_ready, 1);
    tick();

    // Fill the whole memory so every later read has a defined expectation.
    write_burst(0, 7, 0, 8);
    wait_idle();
    write_burst(8, 7, 0, 8);
    wait_idle();

    // Single-beat write then read at address 3.
    wq.push_back(32'hDEADBEEF);
    w0 = we_cnt;
    write_burst(3, 0, 0, 1);
    wait_idle();
    chk("len0_write_count", we_cnt - w0, 1);
    send_req(1'b0, 3, 0);
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge i_clk);
      if (o_rdata_valid) break;
      tick();
      lat++;
    end
    chk("len0_read_latency", lat, 2);
    chk("len0_rdata", o_rdata, 32'hDEADBEEF);
    chk("len0_rlast", o_rdata_last, 1);
    tick();
    wait_drain();

    // Wrapping write at 14 then read back at full rate.
    for (int k = 0; k < 4; k++) wq.push_back(32'hA0 + k);
    wlog.delete();
    write_burst(14, 3, 0, 4);
    wait_idle();
    chk("wrap_write_count", wlog.size(), 4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) chk("wrap_write_addr", wlog[k], waddr[k]);
    rlog.delete(); rcyc.delete();
    send_req(1'b0, 14, 3);
    wait_drain();
    chk("wrap_read_count", rlog.size(), 4);
    for (int k = 0; k < 4 && k < rlog.size(); k++) begin
      chk("wrap_read_data", rlog[k].data, 32'hA0 + k);
      chk("wrap_read_last", rlog[k].last, (k == 3));
      chk("wrap_read_back_to_back", rcyc[k] - rcyc[0], k);
    end

    // Stalled read: only two reads may be in flight while nothing is consumed.
    rdy_mode = 2;
    tick();
    rlog.delete();
    send_req(1'b0, 4, 7);
    for (int n = 0; n < 10; n++) begin
      @(negedge i_clk);
      if (o_rdata_valid) chk("stall_head_stable", o_rdata, ref_mem[4]);
      tick();
    end
    @(negedge i_clk);
    chk("stall_issued_addr", o_mem_addr, 6);
    chk("stall_valid_held", o_rdata_valid, 1);
    chk("stall_head_last", o_rdata_last, 0);
    tick();
    rdy_mode = 0;
    wait_drain();
    chk("stall_read_count", rlog.size(), 8);

    // Toggled write valid with request noise during the burst.
    w0 = we_cnt;
    write_burst(10, 3, 1, 4);
    @(negedge i_clk);
    chk("toggle_idle_after_last", o_busy, 0);
    chk("toggle_write_count", we_cnt - w0, 4);
    chk("toggle_no_extra_writes", exp_wr.size(), 0);
    tick();

    // Reset after two of four write beats.
    w0 = we_cnt;
    write_burst(0, 3, 0, 2);
    i_wdata_valid = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", o_mem_we, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_req_ready", o_req_ready, 0);
    chk("midrst_wdata_ready", o_wdata_ready, 0);
    chk("midrst_writes_done", we_cnt - w0, 2);
    chk("midrst_pending_writes", exp_wr.size(), 2);
    exp_wr.delete();
    tick(); tick();
    i_wdata_valid = 1'b0;
    i_rst_n = 1'b1;
    tick(); tick();
    @(negedge i_clk);
    chk("midrst_ready_after", o_req_ready, 1);
    chk("midrst_mem_we_after", o_mem_we, 0);
    tick();
    rdy_mode = 1;
    send_req(1'b0, 0, 3);
    wait_drain();
    rdy_mode = 0;

    // Back-to-back two-beat reads.
    rlog.delete();
    send_req(1'b0, 5, 1);
    idle_cnt = 0;
    send_req(1'b0, 7, 1);
    chk("b2b_idle_cycles", idle_cnt, 1);
    wait_drain();
    chk("b2b_beats", rlog.size(), 4);
    for (int k = 0; k < 4 && k < rlog.size(); k++) chk("b2b_last", rlog[k].last, (k % 2 == 1));

    // Random mix of bursts with random back-pressure.
    for (int n = 0; n < 30; n++) begin
      int a = $urandom_range(0, D - 1);
      int l = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) write_burst(a, l, 0, l + 1);
      else begin
        rdy_mode = $urandom_range(0, 1);
        send_req(1'b0, a, l);
      end
    end
    rdy_mode = 0;
    wait_drain();
    chk("final_exp_wr_empty", exp_wr.size(), 0);
    chk("final_exp_rd_empty", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
